// File: rtl/psum_sram_rd_stream.sv
// rtl/psum_sram_rd_stream.sv - psum SRAM read controller streaming N groups of words to the accumulator
module psum_sram_rd_stream #(
   parameter int BATCHES  = 4,
   parameter int CHANNELS = 3,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 21
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [7:0]               num_groups,
   input  logic                     hold,
   output logic                     sram_ren,
   output logic [ADDR_W-1:0]        sram_addr,
   input  logic [DATA_W-1:0]        sram_rdata,
   output logic                     acc_en,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     data_out_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int WPG = BATCHES * CHANNELS;
   localparam int KW  = (WPG > 1) ? $clog2(WPG) : 1;

   typedef enum logic [2:0] {IDLE, PRIME, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        n_q;
   logic [7:0]        g_q;
   logic [KW-1:0]     k_q;
   logic              rd_pend;
   logic              last_word;

   // A read is issued in the same cycle hold is seen low, so hold gaps map 1:1 onto valid gaps.
   assign sram_ren  = (state == READ) && !hold;
   assign sram_addr = addr_q;
   assign last_word = (k_q == KW'(WPG - 1)) && (g_q == n_q - 8'd1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         addr_q         <= '0;
         n_q            <= '0;
         g_q            <= '0;
         k_q            <= '0;
         rd_pend        <= 1'b0;
         acc_en         <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         rd_pend        <= sram_ren;
         data_out_valid <= rd_pend;
         if (rd_pend)
            data_out <= sram_rdata;
         done <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  if (num_groups != 8'd0) begin
                     addr_q <= base_addr;
                     n_q    <= num_groups;
                     g_q    <= '0;
                     k_q    <= '0;
                     busy   <= 1'b1;
                     acc_en <= 1'b1;
                     state  <= PRIME;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            PRIME: state <= READ;
            READ: begin
               if (!hold) begin
                  addr_q <= addr_q + ADDR_W'(1);
                  if (last_word) begin
                     state <= DRAIN;
                  end else if (k_q == KW'(WPG - 1)) begin
                     k_q <= '0;
                     g_q <= g_q + 8'd1;
                  end else begin
                     k_q <= k_q + KW'(1);
                  end
               end
            end
            // rd_pend low here means the final word is on data_out this cycle.
            DRAIN: begin
               if (!rd_pend) begin
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  acc_en <= 1'b0;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_sram_rd_stream.sv
// tb/tb_psum_sram_rd_stream.sv - self-checking bench for psum_sram_rd_stream
module tb_psum_sram_rd_stream;
   localparam int AW = 10;
   localparam int DW = 21;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          hold = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [7:0]    num_groups = '0;
   logic          sram_ren;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_rdata = '0;
   logic          acc_en;
   logic [DW-1:0] data_out;
   logic          data_out_valid;
   logic          busy;
   logic          done;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            cyc = 0;

   psum_sram_rd_stream #(.BATCHES(4), .CHANNELS(3), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .num_groups(num_groups), .hold(hold), .sram_ren(sram_ren), .sram_addr(sram_addr),
      .sram_rdata(sram_rdata), .acc_en(acc_en), .data_out(data_out),
      .data_out_valid(data_out_valid), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (sram_ren) sram_rdata <= mem[sram_addr];
   end

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Model: a transfer is a list of addresses to read; each read shows up as a
   // valid word two cycles later, and the run ends on the last word.
   bit            run, engaged, done_next, accept;
   int            prime_cnt, emit_left;
   logic [AW-1:0] exp_addr[$];
   bit            pv[2];
   logic [DW-1:0] pd[2];
   logic [DW-1:0] last_data;
   bit            e_ren, e_valid, e_done;
   logic [DW-1:0] e_data;

   logic [AW-1:0] addr_log[$];
   logic [DW-1:0] data_log[$];
   int ren_count, valid_count, acc_count, done_count;
   int first_valid_cyc, last_valid_cyc, done_cyc;

   task automatic clear_logs();
      addr_log.delete();
      data_log.delete();
      ren_count = 0; valid_count = 0; acc_count = 0; done_count = 0;
      first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         run = 0; engaged = 0; done_next = 0; prime_cnt = 0; emit_left = 0;
         exp_addr.delete();
         pv[0] = 0; pv[1] = 0; last_data = '0;
         chk("rst_ren", sram_ren, 0);
         chk("rst_addr", sram_addr, 0);
         chk("rst_valid", data_out_valid, 0);
         chk("rst_data", data_out, 0);
         chk("rst_acc", acc_en, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
      end else begin
         e_ren   = run && prime_cnt == 0 && exp_addr.size() > 0 && !hold;
         e_valid = pv[1];
         e_data  = pd[1];
         e_done  = done_next;
         chk("sram_ren", sram_ren, e_ren);
         if (e_ren) chk("sram_addr", sram_addr, exp_addr[0]);
         chk("data_out_valid", data_out_valid, e_valid);
         chk("data_out", data_out, e_valid ? e_data : last_data);
         chk("acc_en", acc_en, run);
         chk("busy", busy, run);
         chk("done", done, e_done);

         if (sram_ren) begin addr_log.push_back(sram_addr); ren_count++; end
         if (data_out_valid) begin
            data_log.push_back(data_out);
            valid_count++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
         end
         if (acc_en) acc_count++;
         if (done) begin done_count++; done_cyc = cyc; end

         done_next = 0;
         if (e_valid) begin
            emit_left--;
            last_data = e_data;
            if (emit_left == 0) begin run = 0; done_next = 1; end
         end
         accept = start && !engaged;
         if (e_done) engaged = 0;
         pv[1] = pv[0]; pd[1] = pd[0];
         pv[0] = e_ren;
         pd[0] = e_ren ? mem[exp_addr[0]] : '0;
         if (e_ren) void'(exp_addr.pop_front());
         if (prime_cnt > 0) prime_cnt--;
         if (accept) begin
            engaged = 1;
            if (num_groups == 0) done_next = 1;
            else begin
               run = 1; prime_cnt = 1; emit_left = 12 * num_groups;
               for (int i = 0; i < 12 * num_groups; i++) exp_addr.push_back(AW'(base_addr + i));
            end
         end
      end
   end

   task automatic run_xfer(input logic [AW-1:0] b, input logic [7:0] n, input int h0, input int h1,
                           input int s2, output int a);
      bit fin;
      fin = 0;
      @(posedge clock); #1;
      start = 1; base_addr = b; num_groups = n; a = cyc;
      for (int i = 1; i < 400 && !fin; i++) begin
         @(posedge clock); #1;
         start = (i == s2);
         if (i == s2) begin base_addr = 10'h200; num_groups = 8'd1; end
         hold = (i >= h0 && i <= h1);
         if (done) fin = 1;
      end
      if (!fin) chk("run_timeout", 0, 1);
      start = 0; hold = 0;
      @(posedge clock); #1;
   endtask

   int a;
   int nv;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 37) ^ 21'h100000;
      for (int k = 0; k < 12; k++) mem[10'h010 + k] = DW'(k + 1);

      repeat (3) @(posedge clock);
      #1 reset = 1;
      clear_logs();
      repeat (5) @(posedge clock);
      #1;
      chk("idle_ren_count", ren_count, 0);
      chk("idle_acc_count", acc_count, 0);
      chk("idle_addr", sram_addr, 0);
      chk("idle_data", data_out, 0);

      // N=1, base 0x010, no hold
      clear_logs();
      run_xfer(10'h010, 8'd1, -1, -1, -1, a);
      for (int k = 0; k < 12; k++) chk("n1_addr", addr_log[k], 10'h010 + k);
      for (int k = 0; k < 12; k++) chk("n1_data", data_log[k], k + 1);
      chk("n1_first_valid", first_valid_cyc - a, 4);
      chk("n1_valid_count", valid_count, 12);
      chk("n1_done_after_last", done_cyc - last_valid_cyc, 1);
      chk("n1_acc_count", acc_count, 15);
      chk("n1_batch0", data_log[0] + data_log[4] + data_log[8], 15);
      chk("n1_batch1", data_log[1] + data_log[5] + data_log[9], 18);
      chk("n1_batch2", data_log[2] + data_log[6] + data_log[10], 21);
      chk("n1_batch3", data_log[3] + data_log[7] + data_log[11], 24);

      // N=2 across the top of the address space
      clear_logs();
      run_xfer(10'h3F8, 8'd2, -1, -1, -1, a);
      chk("wrap_addr7", addr_log[7], 10'h3FF);
      chk("wrap_addr8", addr_log[8], 10'h000);
      chk("wrap_last", addr_log[23], 10'h00F);
      chk("wrap_valids", valid_count, 24);
      chk("wrap_dones", done_count, 1);

      // N=1 with hold over the k=4 and k=5 read slots
      clear_logs();
      run_xfer(10'h010, 8'd1, 6, 7, -1, a);
      for (int k = 0; k < 12; k++) chk("hold_data", data_log[k], k + 1);
      chk("hold_span", last_valid_cyc - first_valid_cyc, 13);
      chk("hold_done", done_cyc - a, 18);
      chk("hold_acc", acc_count, done_cyc - a - 1);

      // N=0: immediate done, no reads
      clear_logs();
      run_xfer(10'h050, 8'd0, -1, -1, -1, a);
      chk("n0_done", done_cyc - a, 1);
      chk("n0_ren", ren_count, 0);
      chk("n0_acc", acc_count, 0);

      // N=3 with a stray start mid-run
      clear_logs();
      run_xfer(10'h040, 8'd3, -1, -1, 10, a);
      chk("n3_valids", valid_count, 36);
      chk("n3_dones", done_count, 1);
      chk("n3_first", addr_log[0], 10'h040);
      chk("n3_last", addr_log[35], 10'h063);
      repeat (3) @(posedge clock);
      #1 chk("n3_no_restart", ren_count, 36);

      // reset at the 6th valid of an N=2 run
      clear_logs();
      @(posedge clock); #1;
      start = 1; base_addr = 10'h100; num_groups = 8'd2;
      @(posedge clock); #1;
      start = 0;
      nv = 0;
      for (int i = 0; i < 100 && nv < 6; i++) begin
         @(posedge clock); #1;
         if (data_out_valid) nv++;
      end
      chk("abort_reached6", nv, 6);
      reset = 0;
      #1;
      chk("abort_ren", sram_ren, 0);
      chk("abort_valid", data_out_valid, 0);
      chk("abort_acc", acc_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_data", data_out, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1;
      repeat (2) @(posedge clock);
      #1 chk("abort_no_done", done_count, 0);
      clear_logs();
      run_xfer(10'h120, 8'd1, -1, -1, -1, a);
      chk("restart_first", addr_log[0], 10'h120);
      chk("restart_valids", valid_count, 12);
      chk("restart_dones", done_count, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
